// File: rtl/calc_keypad_cmd_encoder.sv
// Scans a 4x4 active-low matrix keypad, debounces press and release, and issues one
// 4-bit command per physical key press, held for a fixed window toward calc_top.
module calc_keypad_cmd_encoder #(
  parameter int          SCAN_DIV        = 16,
  parameter int          DEBOUNCE_CYCLES = 1000,
  parameter int          CMD_HOLD        = 10,
  parameter logic [3:0]  IDLE_CMD        = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] key_row,
  input  logic [3:0] key_col,
  input  logic       calc_busy,
  output logic [3:0] cmd,
  output logic       cmd_valid
);

  localparam int MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_P = (MAX_A > CMD_HOLD) ? MAX_A : CMD_HOLD;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] SCAN_LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST     = CW'(CMD_HOLD - 1);
  localparam logic [CW-1:0] CNT_ZERO      = '0;
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [3:0]    RESERVED_CODE = 4'hF;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PENDING,
    EMIT,
    RELEASE
  } state_e;

  state_e        state_q;
  logic [1:0]    row_q;
  logic [1:0]    col_q;
  logic [3:0]    code_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    colMeta_q;
  logic [3:0]    colS_q;
  logic [3:0]    cmd_q;
  logic          cmdValid_q;

  logic          anyLow;
  logic [1:0]    lowCol;
  logic          keyUp;

  // Two-flop synchronizer; idle columns read high so reset matches "no key".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      colMeta_q <= 4'b1111;
      colS_q    <= 4'b1111;
    end else begin
      colMeta_q <= key_col;
      colS_q    <= colMeta_q;
    end
  end

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    anyLow = 1'b0;
    lowCol = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!colS_q[i]) begin
        anyLow = 1'b1;
        lowCol = 2'(i);
      end
    end
  end

  assign keyUp = colS_q[col_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      code_q     <= 4'd0;
      cnt_q      <= CNT_ZERO;
      cmd_q      <= IDLE_CMD;
      cmdValid_q <= 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= CNT_ZERO;
            if (anyLow) begin
              col_q   <= lowCol;
              code_q  <= {row_q, lowCol};
              state_q <= DEBOUNCE;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DEBOUNCE: begin
          if (keyUp) begin
            cnt_q   <= CNT_ZERO;
            state_q <= SCAN;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q <= CNT_ZERO;
            if (code_q == RESERVED_CODE) begin
              state_q <= RELEASE;
            end else if (calc_busy) begin
              state_q <= PENDING;
            end else begin
              state_q    <= EMIT;
              cmd_q      <= code_q;
              cmdValid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // Code stays latched here even if the key is released while waiting.
        PENDING: begin
          if (!calc_busy) begin
            cnt_q      <= CNT_ZERO;
            state_q    <= EMIT;
            cmd_q      <= code_q;
            cmdValid_q <= 1'b1;
          end
        end

        EMIT: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q      <= CNT_ZERO;
            cmd_q      <= IDLE_CMD;
            cmdValid_q <= 1'b0;
            state_q    <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        RELEASE: begin
          if (!keyUp) begin
            cnt_q <= CNT_ZERO;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q   <= CNT_ZERO;
            row_q   <= row_q + 2'd1;
            state_q <= SCAN;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          cnt_q      <= CNT_ZERO;
          cmd_q      <= IDLE_CMD;
          cmdValid_q <= 1'b0;
          state_q    <= SCAN;
        end
      endcase
    end
  end

  assign key_row   = ~(4'b0001 << row_q);
  assign cmd       = cmd_q;
  assign cmd_valid = cmdValid_q;

endmodule

// File: tb/tb_calc_keypad_cmd_encoder.sv
// Directed bench for calc_keypad_cmd_encoder: a keypad matrix model drives the columns
// from the scanned rows, and a monitor records every cmd_valid burst for checking.
module tb_calc_keypad_cmd_encoder;

  logic        clock;
  logic        reset;
  logic [3:0]  keyRow;
  logic [3:0]  keyCol;
  logic        calcBusy;
  logic [3:0]  cmd;
  logic        cmdValid;

  logic [15:0] pressedKeys;

  int assertCount = 0;
  int failCount   = 0;
  int base;

  logic [3:0] rowSeq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [3:0] seqCodes [4] = '{4'h1, 4'hA, 4'h2, 4'hE};

  logic       prevValid = 1'b0;
  int         runLen    = 0;
  logic [3:0] runCode   = 4'h0;
  logic [3:0] emitCode [$];
  int         emitLen  [$];
  int         changeErr = 0;
  int         idleErr   = 0;

  calc_keypad_cmd_encoder #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .CMD_HOLD        (10),
    .IDLE_CMD        (4'hF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_row   (keyRow),
    .key_col   (keyCol),
    .calc_busy (calcBusy),
    .cmd       (cmd),
    .cmd_valid (cmdValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its column low only while its row is driven low.
  always_comb begin
    keyCol = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressedKeys[r*4+c] && !keyRow[r]) keyCol[c] = 1'b0;
      end
    end
  end

  // Records each cmd_valid burst (code, length) and flags any unstable or non-idle cmd.
  always @(negedge clock) begin
    if (cmdValid === 1'b1) begin
      if (!prevValid) begin
        runCode = cmd;
        runLen  = 1;
      end else begin
        runLen++;
        if (cmd !== runCode) changeErr++;
      end
    end else begin
      if (prevValid) begin
        emitCode.push_back(runCode);
        emitLen.push_back(runLen);
      end
      if (cmd !== 4'hF) idleErr++;
    end
    prevValid = (cmdValid === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] keyBit(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r * 4 + c);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic busy);
    pressedKeys = keys;
    calcBusy    = busy;
  endtask

  task automatic pressHold(input logic [15:0] keys);
    applyStimulus(keys, 1'b0);
    repeat (40) @(negedge clock);
    applyStimulus(16'h0000, 1'b0);
    repeat (30) @(negedge clock);
  endtask

  // Returns on the first negedge after key_row switches to rowVal.
  task automatic waitRowStart(input logic [3:0] rowVal);
    int n;
    n = 0;
    while (keyRow === rowVal && n < 100) begin
      @(negedge clock);
      n++;
    end
    while (keyRow !== rowVal && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("rowStartReached", {28'd0, keyRow}, {28'd0, rowVal});
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("resetCmd",   {28'd0, cmd},      32'hF);
    checkOutput("resetValid", {31'd0, cmdValid}, 32'd0);
    checkOutput("resetRow",   {28'd0, keyRow},   32'b1110);

    reset = 1'b1;
    checkOutput("rowAtRelease", {28'd0, keyRow}, {28'd0, rowSeq[0]});
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clock);
      checkOutput("rowRotate", {28'd0, keyRow}, {28'd0, rowSeq[i]});
    end

    $display("[TB] sequence 1,A,2,E with press latency");
    waitRowStart(4'b1110);
    base = emitCode.size();
    applyStimulus(keyBit(0, 1), 1'b0);
    repeat (11) @(negedge clock);
    checkOutput("latencyNotYet", {31'd0, cmdValid}, 32'd0);
    @(negedge clock);
    checkOutput("latencyValid", {31'd0, cmdValid}, 32'd1);
    checkOutput("latencyCmd",   {28'd0, cmd},      32'h1);
    repeat (9) @(negedge clock);
    checkOutput("holdLastCycle", {31'd0, cmdValid}, 32'd1);
    @(negedge clock);
    checkOutput("holdEndValid", {31'd0, cmdValid}, 32'd0);
    checkOutput("holdEndCmd",   {28'd0, cmd},      32'hF);
    repeat (18) @(negedge clock);
    applyStimulus(16'h0000, 1'b0);
    repeat (30) @(negedge clock);
    pressHold(keyBit(2, 2));
    pressHold(keyBit(0, 2));
    pressHold(keyBit(3, 2));
    #1;
    checkOutput("seqCount", emitCode.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("seqCode", {28'd0, emitCode[base+i]}, {28'd0, seqCodes[i]});
      checkOutput("seqLen",  emitLen[base+i],            32'd10);
    end

    $display("[TB] bounce on row1/col0");
    waitRowStart(4'b1101);
    base = emitCode.size();
    applyStimulus(keyBit(1, 0), 1'b0);
    repeat (3) @(negedge clock);
    applyStimulus(16'h0000, 1'b0);
    repeat (6) @(negedge clock);
    checkOutput("bounceRowHeld", {28'd0, keyRow}, 32'b1101);
    @(negedge clock);
    checkOutput("bounceRowNext", {28'd0, keyRow}, 32'b1011);
    repeat (30) @(negedge clock);
    #1;
    checkOutput("bounceNoEmit", emitCode.size(), base);

    $display("[TB] busy deferral on row2/col2");
    waitRowStart(4'b1011);
    base = emitCode.size();
    applyStimulus(keyBit(2, 2), 1'b1);
    repeat (15) @(negedge clock);
    applyStimulus(16'h0000, 1'b1);
    repeat (5) @(negedge clock);
    checkOutput("busyMidValid", {31'd0, cmdValid}, 32'd0);
    checkOutput("busyMidCmd",   {28'd0, cmd},      32'hF);
    repeat (10) @(negedge clock);
    checkOutput("busyLastValid", {31'd0, cmdValid}, 32'd0);
    applyStimulus(16'h0000, 1'b0);
    @(negedge clock);
    checkOutput("busyFallValid", {31'd0, cmdValid}, 32'd1);
    checkOutput("busyFallCmd",   {28'd0, cmd},      32'hA);
    repeat (2) @(negedge clock);
    applyStimulus(16'h0000, 1'b1);
    repeat (3) @(negedge clock);
    applyStimulus(16'h0000, 1'b0);
    repeat (30) @(negedge clock);
    #1;
    checkOutput("busyCount", emitCode.size(), base + 1);
    checkOutput("busyCode",  {28'd0, emitCode[base]}, 32'hA);
    checkOutput("busyLen",   emitLen[base],           32'd10);

    $display("[TB] reserved code and multi-key press");
    base = emitCode.size();
    pressHold(keyBit(3, 3));
    #1;
    checkOutput("reservedNoEmit", emitCode.size(), base);
    pressHold(keyBit(0, 2) | keyBit(0, 3));
    #1;
    checkOutput("multiCount", emitCode.size(), base + 1);
    checkOutput("multiCode",  {28'd0, emitCode[base]}, 32'h2);
    checkOutput("multiLen",   emitLen[base],           32'd10);

    $display("[TB] reset during emission");
    waitRowStart(4'b1110);
    base = emitCode.size();
    applyStimulus(keyBit(0, 1), 1'b0);
    repeat (16) @(negedge clock);
    checkOutput("fifthEmitValid", {31'd0, cmdValid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midResetCmd",   {28'd0, cmd},      32'hF);
    checkOutput("midResetValid", {31'd0, cmdValid}, 32'd0);
    checkOutput("midResetRow",   {28'd0, keyRow},   32'b1110);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i < 12; i++) begin
      @(negedge clock);
      checkOutput("noEarlyEmit", {31'd0, cmdValid}, 32'd0);
    end
    @(negedge clock);
    checkOutput("reDebounceValid", {31'd0, cmdValid}, 32'd1);
    checkOutput("reDebounceCmd",   {28'd0, cmd},      32'h1);
    repeat (9) @(negedge clock);
    applyStimulus(16'h0000, 1'b0);
    repeat (30) @(negedge clock);
    #1;
    checkOutput("resetRunCount", emitCode.size(), base + 2);
    checkOutput("cutRunCode",    {28'd0, emitCode[base]}, 32'h1);
    checkOutput("cutRunLen",     emitLen[base],           32'd5);
    checkOutput("fullRunLen",    emitLen[base+1],         32'd10);

    checkOutput("cmdStableWhileValid", changeErr, 32'd0);
    checkOutput("cmdIdleWhenInvalid",  idleErr,   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
